// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns execute-stage jump/hold requests into
// PC, IF/ID and ID/EX control, with a stall watchdog and event counters.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        pc_jump_en_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_flush_o,
  output logic        hold_timeout_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0]  FLUSH_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] HOLD_LIMIT   = 16'(HOLD_TIMEOUT);
  localparam bit          MULTI_BUBBLE = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  logic        accept_jump;
  logic        do_hold;
  logic        do_flush;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    hcnt_d      = hcnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    accept_jump = 1'b0;
    do_hold     = 1'b0;
    do_flush    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (jump_en_i) begin
          accept_jump = 1'b1;
        end else if (hold_flag_i) begin
          do_hold     = 1'b1;
          state_d     = S_HOLD;
          hcnt_d      = 16'd1;
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end
      S_HOLD: begin
        // An ongoing hold outranks a jump; the jump is re-presented once hold drops.
        if (hold_flag_i) begin
          do_hold     = 1'b1;
          hcnt_d      = (hcnt_q >= HOLD_LIMIT) ? HOLD_LIMIT : hcnt_q + 16'd1;
          stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
          hcnt_d  = 16'd0;
          state_d = S_RUN;
          if (jump_en_i) accept_jump = 1'b1;
        end
      end
      S_FLUSH: begin
        do_flush = 1'b1;
        fcnt_d   = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) begin
          fcnt_d  = 4'd0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (accept_jump) begin
      do_flush    = 1'b1;
      flush_cnt_d = flush_cnt_q + 32'd1;
      if (MULTI_BUBBLE) begin
        state_d = S_FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  assign timeout_d = timeout_q | ((state_d == S_HOLD) && (hcnt_d == HOLD_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_RUN;
      fcnt_q      <= 4'd0;
      hcnt_q      <= 16'd0;
      flush_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      hcnt_q      <= hcnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Combinational controls are gated so nothing leaks out while reset is held.
  assign pc_jump_en_o   = rst_n & accept_jump;
  assign pc_jump_addr_o = (rst_n && accept_jump) ? jump_addr_i : 32'd0;
  assign pc_hold_o      = rst_n & do_hold;
  assign if_id_hold_o   = rst_n & do_hold;
  assign id_ex_hold_o   = rst_n & do_hold;
  assign if_id_flush_o  = rst_n & do_flush;
  assign id_ex_flush_o  = rst_n & do_flush;
  assign hold_timeout_o = timeout_q;
  assign flush_cnt_o    = flush_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances share stimulus, one with default
// parameters and one with FLUSH_CYCLES=4, HOLD_TIMEOUT=4.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold_flag;

  logic        a_pc_jump_en, a_pc_hold, a_if_id_hold, a_if_id_flush, a_id_ex_hold, a_id_ex_flush;
  logic        a_timeout;
  logic [31:0] a_pc_jump_addr, a_flush_cnt, a_stall_cnt;
  logic        b_pc_jump_en, b_pc_hold, b_if_id_hold, b_if_id_flush, b_id_ex_hold, b_id_ex_flush;
  logic        b_timeout;
  logic [31:0] b_pc_jump_addr, b_flush_cnt, b_stall_cnt;

  logic [5:0]  ctl_a, ctl_b;

  // Control bit order: {pc_jump_en, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush}
  localparam logic [5:0] CTL_IDLE  = 6'b000000;
  localparam logic [5:0] CTL_JUMP  = 6'b100101;
  localparam logic [5:0] CTL_FLUSH = 6'b000101;
  localparam logic [5:0] CTL_HOLD  = 6'b011010;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .hold_flag_i    (hold_flag),
    .pc_jump_en_o   (a_pc_jump_en),
    .pc_jump_addr_o (a_pc_jump_addr),
    .pc_hold_o      (a_pc_hold),
    .if_id_hold_o   (a_if_id_hold),
    .if_id_flush_o  (a_if_id_flush),
    .id_ex_hold_o   (a_id_ex_hold),
    .id_ex_flush_o  (a_id_ex_flush),
    .hold_timeout_o (a_timeout),
    .flush_cnt_o    (a_flush_cnt),
    .stall_cnt_o    (a_stall_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(4), .HOLD_TIMEOUT(4)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .hold_flag_i    (hold_flag),
    .pc_jump_en_o   (b_pc_jump_en),
    .pc_jump_addr_o (b_pc_jump_addr),
    .pc_hold_o      (b_pc_hold),
    .if_id_hold_o   (b_if_id_hold),
    .if_id_flush_o  (b_if_id_flush),
    .id_ex_hold_o   (b_id_ex_hold),
    .id_ex_flush_o  (b_id_ex_flush),
    .hold_timeout_o (b_timeout),
    .flush_cnt_o    (b_flush_cnt),
    .stall_cnt_o    (b_stall_cnt)
  );

  assign ctl_a = {a_pc_jump_en, a_pc_hold, a_if_id_hold, a_if_id_flush, a_id_ex_hold, a_id_ex_flush};
  assign ctl_b = {b_pc_jump_en, b_pc_hold, b_if_id_hold, b_if_id_flush, b_id_ex_hold, b_id_ex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change here, checks follow #1 later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic [31:0] addr, input logic h);
    jump_en   = j;
    jump_addr = addr;
    hold_flag = h;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    next();
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset: outputs must stay 0 even with requests applied.
    rst_n = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    #2;
    check("rst_ctl_jump", ctl_a, CTL_IDLE);
    check("rst_addr", a_pc_jump_addr, 32'd0);
    drive(1'b0, 32'd0, 1'b1);
    #1;
    check("rst_ctl_hold", ctl_a, CTL_IDLE);
    drive(1'b0, 32'd0, 1'b0);
    next();
    next();
    rst_n = 1'b1;
    #1;
    check("rst_flush_cnt", a_flush_cnt, 32'd0);
    check("rst_stall_cnt", a_stall_cnt, 32'd0);
    check("rst_timeout", a_timeout, 32'd0);
    check("rst_idle", ctl_a, CTL_IDLE);

    // Single jump, FLUSH_CYCLES=2.
    next();
    drive(1'b1, 32'h0000_0040, 1'b0);
    #1;
    check("jmp_T_ctl", ctl_a, CTL_JUMP);
    check("jmp_T_addr", a_pc_jump_addr, 32'h0000_0040);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("jmp_T1_ctl", ctl_a, CTL_FLUSH);
    check("jmp_flush_cnt", a_flush_cnt, 32'd1);
    next();
    #1;
    check("jmp_T2_ctl", ctl_a, CTL_IDLE);

    // Hold for exactly 5 cycles.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      #1;
      check($sformatf("hold5_c%0d", i), ctl_a, CTL_HOLD);
      next();
    end
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("hold5_release", ctl_a, CTL_IDLE);
    check("hold5_stall_cnt", a_stall_cnt, 32'd5);
    check("hold5_timeout", a_timeout, 32'd0);

    // Jump and hold together in RUN: jump wins.
    next();
    drive(1'b1, 32'h0000_0100, 1'b1);
    #1;
    check("both_run_ctl", ctl_a, CTL_JUMP);
    check("both_run_addr", a_pc_jump_addr, 32'h0000_0100);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("both_run_flush", ctl_a, CTL_FLUSH);
    check("both_run_stall", a_stall_cnt, 32'd5);
    check("both_run_fcnt", a_flush_cnt, 32'd2);
    next();
    #1;
    check("both_run_idle", ctl_a, CTL_IDLE);

    // Jump while already holding is ignored until hold falls.
    drive(1'b0, 32'd0, 1'b1);
    #1;
    check("hj_enter", ctl_a, CTL_HOLD);
    next();
    drive(1'b1, 32'h0000_0200, 1'b1);
    #1;
    check("hj_ignored_ctl", ctl_a, CTL_HOLD);
    check("hj_ignored_addr", a_pc_jump_addr, 32'd0);
    next();
    drive(1'b1, 32'h0000_0200, 1'b0);
    #1;
    check("hj_jump_ctl", ctl_a, CTL_JUMP);
    check("hj_jump_addr", a_pc_jump_addr, 32'h0000_0200);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("hj_flush", ctl_a, CTL_FLUSH);
    check("hj_flush_cnt", a_flush_cnt, 32'd3);
    check("hj_stall_cnt", a_stall_cnt, 32'd7);
    next();
    #1;
    check("hj_idle", ctl_a, CTL_IDLE);

    // Watchdog on dut_b (HOLD_TIMEOUT=4): hold for 6 cycles.
    do_reset();
    #1;
    check("wd_start", b_timeout, 32'd0);
    next();
    drive(1'b0, 32'd0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next();
      #1;
      check($sformatf("wd_edge%0d", k), b_timeout, (k >= 4) ? 32'd1 : 32'd0);
      if (k == 5) check("wd_hold_kept", ctl_b, CTL_HOLD);
    end
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("wd_release_ctl", ctl_b, CTL_IDLE);
    next();
    next();
    #1;
    check("wd_sticky", b_timeout, 32'd1);
    check("wd_stall_cnt", b_stall_cnt, 32'd6);
    rst_n = 1'b0;
    #1;
    check("wd_cleared", b_timeout, 32'd0);
    next();
    rst_n = 1'b1;

    // Reset in the second flush cycle of dut_b (FLUSH_CYCLES=4).
    next();
    drive(1'b1, 32'h0000_0080, 1'b0);
    #1;
    check("rf_T_ctl", ctl_b, CTL_JUMP);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("rf_T1_ctl", ctl_b, CTL_FLUSH);
    rst_n = 1'b0;
    #1;
    check("rf_rst_ctl", ctl_b, CTL_IDLE);
    check("rf_rst_cnt", b_flush_cnt, 32'd0);
    next();
    rst_n = 1'b1;
    #1;
    check("rf_after_ctl", ctl_b, CTL_IDLE);
    next();
    #1;
    check("rf_no_bubble", ctl_b, CTL_IDLE);
    check("rf_cnt_zero", b_flush_cnt, 32'd0);

    // Full 4-bubble jump; requests during FLUSH are ignored.
    drive(1'b1, 32'h0000_0C00, 1'b0);
    #1;
    check("f4_T0", ctl_b, CTL_JUMP);
    next();
    drive(1'b1, 32'h0000_0D00, 1'b1);
    #1;
    check("f4_T1_ignore", ctl_b, CTL_FLUSH);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("f4_T2", ctl_b, CTL_FLUSH);
    next();
    #1;
    check("f4_T3", ctl_b, CTL_FLUSH);
    next();
    #1;
    check("f4_T4_idle", ctl_b, CTL_IDLE);
    check("f4_flush_cnt", b_flush_cnt, 32'd1);
    check("f4_stall_cnt", b_stall_cnt, 32'd0);

    // Stall counter wrap on dut_a.
    next();
    force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.stall_cnt_q;
    drive(1'b0, 32'd0, 1'b1);
    next();
    drive(1'b0, 32'd0, 1'b0);
    #1;
    check("wrap_stall_cnt", a_stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
